countdown_timer_mmss: RTL and testbench

//  Preset MM:SS countdown timer: the down-counting counterpart of the start/stop chronometer chain.

---
 rtl/countdown_timer_mmss_pkg.sv | 18 +
 rtl/countdown_timer_mmss_tick_prescaler.sv | 39 +++
 rtl/countdown_timer_mmss.sv | 137 +++++++++++++
 tb/tb_countdown_timer_mmss.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_mmss_pkg.sv
// Shared types and limits for the MM:SS countdown timer.
package countdown_timer_mmss_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd99;

  function automatic logic [7:0] clamp_u8(input logic [7:0] val, input logic [7:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/countdown_timer_mmss_tick_prescaler.sv
// Divides the system clock to a one-cycle tick every TICK_PERIOD enabled cycles.
module countdown_timer_mmss_tick_prescaler
  import countdown_timer_mmss_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick fires on the same edge the counter wraps, so the caller acts on that edge.
  assign tick_o = en_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_mmss.sv
// Preset MM:SS countdown timer with start/stop toggle, timed alarm pulse and sticky done flag.
module countdown_timer_mmss
  import countdown_timer_mmss_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = 50_000_000,
  parameter int unsigned ALARM_LEN   = 25_000_000
) (
  input  logic       qzt_clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam int unsigned AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
  localparam logic [AW-1:0] AlarmLast = AW'(ALARM_LEN - 1);

  state_e        state_q, state_d;
  logic [7:0]    min_q, min_d, sec_q, sec_d;
  logic          done_q, done_d, alarm_q, alarm_d, running_q;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          ss_old_q, ss_edge, load_take, tick;

  assign ss_edge   = start_stop & ~ss_old_q;
  assign load_take = load && (state_q != StRun);

  countdown_timer_mmss_tick_prescaler #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_prescaler (
    .clk_i (qzt_clk),
    .rst_ni(reset_n),
    .en_i  (state_q == StRun),
    .clr_i (load_take),
    .tick_o(tick)
  );

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    done_d      = done_q;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;

    if (alarm_q) begin
      if (alarm_cnt_q == AlarmLast) begin
        alarm_d     = 1'b0;
        alarm_cnt_d = '0;
      end else begin
        alarm_cnt_d = alarm_cnt_q + 1'b1;
      end
    end

    if (load_take) begin
      min_d       = clamp_u8(preset_min, MIN_MAX);
      sec_d       = clamp_u8(preset_sec, SEC_MAX);
      done_d      = 1'b0;
      alarm_d     = 1'b0;
      alarm_cnt_d = '0;
      state_d     = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_edge && (min_q != 8'd0 || sec_q != 8'd0)) state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            if (sec_q == 8'd0) begin
              sec_d = SEC_MAX;
              min_d = min_q - 8'd1;
            end else begin
              sec_d = sec_q - 8'd1;
            end
            // Terminal tick wins over a coincident start/stop edge.
            if (min_q == 8'd0 && sec_q == 8'd1) begin
              state_d     = StExpired;
              done_d      = 1'b1;
              alarm_d     = 1'b1;
              alarm_cnt_d = '0;
            end else if (ss_edge) begin
              state_d = StPause;
            end
          end else if (ss_edge) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (ss_edge) state_d = StRun;
        end
        StExpired: begin
          if (ss_edge) begin
            state_d     = StIdle;
            done_d      = 1'b0;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      min_q       <= 8'd0;
      sec_q       <= 8'd0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      ss_old_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      done_q      <= done_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= (state_d == StRun);
      ss_old_q    <= start_stop;
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_countdown_timer_mmss;

  logic       qzt_clk;
  logic       reset_n;
  logic       start_stop;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       alarm;
  logic       done;

  countdown_timer_mmss #(
    .TICK_PERIOD(4),
    .ALARM_LEN  (6)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset_n   (reset_n),
    .start_stop(start_stop),
    .load      (load),
    .preset_min(preset_min),
    .preset_sec(preset_sec),
    .min       (min),
    .sec       (sec),
    .running   (running),
    .alarm     (alarm),
    .done      (done)
  );

  typedef struct {
    string      name;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       run;
    logic       alm;
    logic       dn;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  initial qzt_clk = 1'b0;
  always #5 qzt_clk = ~qzt_clk;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge qzt_clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total_cnt++;
      if (min === mon_e.mn && sec === mon_e.sc && running === mon_e.run &&
          alarm === mon_e.alm && done === mon_e.dn) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got %0d:%0d run=%0b alarm=%0b done=%0b, expected %0d:%0d run=%0b alarm=%0b done=%0b",
                 mon_e.name, min, sec, running, alarm, done,
                 mon_e.mn, mon_e.sc, mon_e.run, mon_e.alm, mon_e.dn);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge qzt_clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input int mn, input int sc,
                           input bit run, input bit alm, input bit dn);
    exp_t e;
    e.name = nm;
    e.mn   = 8'(mn);
    e.sc   = 8'(sc);
    e.run  = run;
    e.alm  = alm;
    e.dn   = dn;
    sb_q.push_back(e);
  endtask

  task automatic press();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic do_load(input int mn, input int sc);
    preset_min = 8'(mn);
    preset_sec = 8'(sc);
    load       = 1'b1;
    step(1);
    load       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    start_stop = 1'b0;
    load       = 1'b0;
    preset_min = 8'd0;
    preset_sec = 8'd0;
    expect_st("reset_state", 0, 0, 0, 0, 0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // Load 01:02 and run through the first decrements, including a borrow.
    do_load(1, 2);
    expect_st("load_0102", 1, 2, 0, 0, 0);
    press();
    expect_st("run_start", 1, 2, 1, 0, 0);
    step(3);
    expect_st("pre_first_dec", 1, 2, 1, 0, 0);
    step(1);
    expect_st("first_dec", 1, 1, 1, 0, 0);
    step(4);
    expect_st("dec_0100", 1, 0, 1, 0, 0);
    step(4);
    expect_st("borrow_0059", 0, 59, 1, 0, 0);
    step(1);

    // Asynchronous reset mid-RUN, checked before any further clock edge.
    reset_n = 1'b0;
    expect_st("async_reset", 0, 0, 0, 0, 0);
    @(negedge qzt_clk);
    #1;
    reset_n = 1'b1;
    step(1);

    // Expiry from 00:02 and alarm pulse length.
    do_load(0, 2);
    expect_st("load_0002", 0, 2, 0, 0, 0);
    press();
    step(4);
    expect_st("exp_dec_0001", 0, 1, 1, 0, 0);
    step(3);
    expect_st("pre_expire", 0, 1, 1, 0, 0);
    step(1);
    expect_st("expire", 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      expect_st("alarm_high", 0, 0, 0, 1, 1);
    end
    step(1);
    expect_st("alarm_fall", 0, 0, 0, 0, 1);
    step(5);
    expect_st("done_sticky", 0, 0, 0, 0, 1);
    step(1);

    // Pause preserves the fractional second; resume completes it in 2 RUN cycles.
    do_load(2, 0);
    press();
    expect_st("pr_running", 2, 0, 1, 0, 0);
    step(1);
    press();
    expect_st("paused", 2, 0, 0, 0, 0);
    step(10);
    expect_st("pause_hold", 2, 0, 0, 0, 0);
    press();
    expect_st("resumed", 2, 0, 1, 0, 0);
    step(1);
    expect_st("resume_hold", 2, 0, 1, 0, 0);
    step(1);
    expect_st("resume_dec", 1, 59, 1, 0, 0);

    // load ignored in RUN.
    preset_min = 8'd0;
    preset_sec = 8'd30;
    load = 1'b1;
    step(1);
    load = 1'b0;
    expect_st("load_in_run", 1, 59, 1, 0, 0);
    press();
    expect_st("pause2", 1, 59, 0, 0, 0);

    // load and start edge together in IDLE: load wins.
    do_load(0, 3);
    expect_st("load_in_pause", 0, 3, 0, 0, 0);
    preset_sec = 8'd4;
    load       = 1'b1;
    start_stop = 1'b1;
    step(1);
    load       = 1'b0;
    start_stop = 1'b0;
    expect_st("load_beats_start", 0, 4, 0, 0, 0);
    step(2);
    expect_st("still_idle", 0, 4, 0, 0, 0);

    // Start at 00:00 stays IDLE.
    do_load(0, 0);
    press();
    expect_st("start_at_zero", 0, 0, 0, 0, 0);
    step(1);

    // Clamping.
    do_load(120, 75);
    expect_st("clamp_both", 99, 59, 0, 0, 0);
    do_load(45, 200);
    expect_st("clamp_sec", 45, 59, 0, 0, 0);
    step(1);

    // Acknowledge mid-alarm.
    do_load(0, 1);
    press();
    step(4);
    expect_st("expire2", 0, 0, 0, 1, 1);
    step(2);
    expect_st("mid_alarm", 0, 0, 0, 1, 1);
    press();
    expect_st("ack_mid_alarm", 0, 0, 0, 0, 0);
    step(8);
    expect_st("ack_stays_idle", 0, 0, 0, 0, 0);
    step(1);

    @(negedge qzt_clk);
    #1;
    if (sb_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
